ahb_decode_ctrl: RTL
====================

# ahb_decode_ctrl

AHB-Lite address decoder and data-phase response controller for the four-slave interconnect. Decodes HADDR in the address phase into one-hot slave selects. Holds the selected slave index through the data phase to steer the slave-to-master read multiplexer. Includes a built-in default slave that returns the two-cycle ERROR response for unmapped transfers, and produces the final HREADY/HRESP seen by the master and all slaves.

## Interface
- REGION0, default 4'h0: HADDR[31:28] value mapped to slave 1
- REGION1, default 4'h1: HADDR[31:28] value mapped to slave 2
- REGION2, default 4'h2: HADDR[31:28] value mapped to slave 3
- REGION3, default 4'h3: HADDR[31:28] value mapped to slave 4
- TIMEOUT_CYCLES, default 256: wait-state limit; only used with the timeout feature
- HCLK  in  1  bus clock; all state on the rising edge
- HRESET  in  1  reset, synchronous, active-high
- HADDR  in  32  master address, address phase
- HTRANS  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- HREADY_MUX  in  1  selected slave HREADY from the response mux
- HRESP_MUX  in  1  selected slave HRESP from the response mux
- HSEL  out  4  one-hot slave select, combinational from HADDR; all zero when unmapped
- MUX_SEL  out  2  registered data-phase slave index, drives the mux `addr` input
- HREADY  out  1  final bus HREADY to master and slaves
- HRESP  out  1  final bus HRESP to master
- TIMEOUT  out  1  one-cycle pulse when a slave times out (0 when the feature is absent)

## Operation
- Decode: HSEL[i]=1 iff HADDR[31:28]==REGIONi. The lowest index wins on duplicate regions. Decode is independent of HTRANS.
- Unmapped hit: no HSEL bit set.
- Active transfer: HTRANS[1]==1.
- Data-phase state updates only on cycles with HREADY==1 (the address phase is accepted).
- FSM states:
  - DP_IDLE: no data phase.
  - DP_SLV: data phase owned by slave MUX_SEL.
  - DP_ERR1, DP_ERR2: default-slave error cycles.
- Transitions on an accepted address phase, from DP_IDLE, DP_SLV or DP_ERR2:
  - Mapped and active: go to DP_SLV and load MUX_SEL from the HSEL index.
  - Unmapped and active: go to DP_ERR1.
  - Not active (IDLE/BUSY): go to DP_IDLE.
- DP_ERR1 always goes to DP_ERR2. DP_ERR2 follows the accepted-address rules above.
- Outputs per state:
  - DP_IDLE: HREADY=1, HRESP=0.
  - DP_SLV: HREADY=HREADY_MUX, HRESP=HRESP_MUX. Slave error responses pass through unchanged.
  - DP_ERR1: HREADY=0, HRESP=1.
  - DP_ERR2: HREADY=1, HRESP=1.
- MUX_SEL holds its value outside DP_SLV loads, so the mux stays stable through wait states.

## Timing
- Reset values: FSM=DP_IDLE, MUX_SEL=0, HREADY=1, HRESP=0, TIMEOUT=0, timeout counter=0.
- Reset asserted mid-transfer or mid-error: state returns to DP_IDLE on the next edge, and any partial response is abandoned.
- HSEL has zero latency (combinational).
- MUX_SEL and the FSM have one-cycle latency from the accepted address phase.
- HREADY/HRESP are combinational from the FSM and the mux inputs. There is no combinational path from HADDR/HTRANS to HREADY.
- Unmapped active transfer: exactly 2 data-phase cycles (ERR1, ERR2).
- Unmapped IDLE/BUSY transfer: zero-wait OKAY.
- Back-to-back transfers: a new address phase accepted in DP_ERR2 or in a final DP_SLV cycle takes effect on the following edge with no bubble.
- Wait states: while in DP_SLV with HREADY_MUX==0, HADDR/HTRANS are ignored.

## Configuration
- Macro: AHB_DECODE_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) increments each DP_SLV cycle with HREADY_MUX==0 and clears on any other cycle.
  - When the count reaches TIMEOUT_CYCLES, the FSM goes to DP_ERR1 and TIMEOUT pulses for 1 cycle.
  - The two-cycle ERROR response is then issued regardless of the slave.
- Not defined: no counter is built, TIMEOUT is tied 0, and slaves may stall indefinitely.

## Structure
- Shared package ahb_pkg holds:
  - the HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
  - the HRESP encodings (OKAY=0, ERROR=1)
  - the data-phase state enum
  - the region-field slice constants (bits 31:28)
- One sub-module, ahb_addr_decode, contains the pure combinational HADDR to HSEL/index/hit decode. The FSM, timeout counter and output muxing stay in the top.

## Test plan
- Reset: hold HRESET 2 cycles with HTRANS=NONSEQ, HADDR=0x2000_0000 -> HREADY=1, HRESP=0, MUX_SEL=0, TIMEOUT=0.
- Mapped read: NONSEQ at 0x2000_0010 with HREADY_MUX=1 -> HSEL=4'b0100 in the same cycle, MUX_SEL=2 in the next cycle, HREADY=1, HRESP=0.
- Unmapped: NONSEQ at 0x9000_0000 -> HSEL=0, then HREADY/HRESP = 0/1 then 1/1. An IDLE at 0x9000_0000 instead gives 1/0 with no wait.
- Wait states: NONSEQ to slave 4, HREADY_MUX low 3 cycles while HADDR changes to 0x0000_0000 -> MUX_SEL stays 3, HREADY low 3 cycles, and the next transfer goes to slave 1 only after release.
- Back-to-back: unmapped NONSEQ, then NONSEQ 0x1000_0000 presented during ERR2 -> MUX_SEL=1 on the cycle after ERR2, no idle gap.
- Timeout (macro defined, TIMEOUT_CYCLES=4): slave 1 holds HREADY_MUX=0 -> TIMEOUT pulses on the 4th stall cycle, then ERR1/ERR2. Without the macro, HREADY stays low for 20 cycles and TIMEOUT stays 0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, data-phase state type and address-region slice constants.
// Imported by the decoder and the decode/response controller.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int REGION_MSB = 31;
  localparam int REGION_LSB = 28;
  localparam int REGION_W   = REGION_MSB - REGION_LSB + 1;

  typedef enum logic [1:0] {
    DP_IDLE = 2'd0,
    DP_SLV  = 2'd1,
    DP_ERR1 = 2'd2,
    DP_ERR2 = 2'd3
  } dp_state_e;

  // NONSEQ and SEQ both carry HTRANS[1] set; IDLE/BUSY never start a data phase.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Purpose: region field of HADDR -> one-hot slave select, binary index and hit flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the address every cycle regardless of HREADY.
module ahb_addr_decode
  import ahb_pkg::*;
#(
  parameter logic [REGION_W-1:0] REGION0 = 4'h0,
  parameter logic [REGION_W-1:0] REGION1 = 4'h1,
  parameter logic [REGION_W-1:0] REGION2 = 4'h2,
  parameter logic [REGION_W-1:0] REGION3 = 4'h3
) (
  input  logic [REGION_W-1:0] region,
  output logic [3:0]          hsel,
  output logic [1:0]          idx,
  output logic                hit
);

  logic [3:0] match;

  assign match = {region == REGION3, region == REGION2,
                  region == REGION1, region == REGION0};

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    hsel = '0;
    idx  = '0;
    hit  = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (match[i]) begin
        hsel    = '0;
        hsel[i] = 1'b1;
        idx     = 2'(i);
        hit     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_decode_ctrl.sv
// Purpose: AHB-Lite address decode, data-phase mux steering and default-slave ERROR response.
// Latency: HSEL combinational; MUX_SEL/state one cycle after an accepted address phase.
// Backpressure: slave HREADY_MUX stalls the data phase; optional AHB_DECODE_TIMEOUT_EN bounds stalls.
module ahb_decode_ctrl
  import ahb_pkg::*;
#(
  parameter logic [3:0] REGION0        = 4'h0,
  parameter logic [3:0] REGION1        = 4'h1,
  parameter logic [3:0] REGION2        = 4'h2,
  parameter logic [3:0] REGION3        = 4'h3,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY_MUX,
  input  logic        HRESP_MUX,
  output logic [3:0]  HSEL,
  output logic [1:0]  MUX_SEL,
  output logic        HREADY,
  output logic        HRESP,
  output logic        TIMEOUT
);

  dp_state_e  state_q, state_d;
  logic [1:0] mux_sel_q, mux_sel_d;
  logic [1:0] dec_idx;
  logic       dec_hit;
  logic       hready_int;
  logic       hresp_int;
  logic       tmo_hit;
  logic       unused_addr;

  assign unused_addr = ^{HADDR[REGION_LSB-1:0], HTRANS[0]};

  ahb_addr_decode #(
    .REGION0 (REGION0),
    .REGION1 (REGION1),
    .REGION2 (REGION2),
    .REGION3 (REGION3)
  ) u_addr_decode (
    .region (HADDR[REGION_MSB:REGION_LSB]),
    .hsel   (HSEL),
    .idx    (dec_idx),
    .hit    (dec_hit)
  );

`ifdef AHB_DECODE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             stall;
  logic [CNT_W-1:0] stall_cnt_q;

  assign stall   = (state_q == DP_SLV) && !HREADY_MUX;
  // Fires on the stall cycle that brings the count to TIMEOUT_CYCLES.
  assign tmo_hit = stall && (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK) begin
    if (HRESET || !stall || tmo_hit) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign TIMEOUT = tmo_hit;
`else
  assign tmo_hit = 1'b0;
  assign TIMEOUT = 1'b0;
`endif

  // Response depends only on state and the slave mux, never on HADDR/HTRANS.
  always_comb begin
    hready_int = 1'b1;
    hresp_int  = HRESP_OKAY;
    case (state_q)
      DP_IDLE: begin
        hready_int = 1'b1;
        hresp_int  = HRESP_OKAY;
      end
      DP_SLV: begin
        hready_int = HREADY_MUX;
        hresp_int  = HRESP_MUX;
      end
      DP_ERR1: begin
        hready_int = 1'b0;
        hresp_int  = HRESP_ERROR;
      end
      DP_ERR2: begin
        hready_int = 1'b1;
        hresp_int  = HRESP_ERROR;
      end
      default: begin
        hready_int = 1'b1;
        hresp_int  = HRESP_OKAY;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mux_sel_d = mux_sel_q;
    if (state_q == DP_ERR1) begin
      state_d = DP_ERR2;
    end else if (hready_int) begin
      if (!htrans_active(HTRANS)) begin
        state_d = DP_IDLE;
      end else if (dec_hit) begin
        state_d   = DP_SLV;
        mux_sel_d = dec_idx;
      end else begin
        state_d = DP_ERR1;
      end
    end
    if (tmo_hit) begin
      state_d = DP_ERR1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= DP_IDLE;
      mux_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      mux_sel_q <= mux_sel_d;
    end
  end

  assign MUX_SEL = mux_sel_q;
  assign HREADY  = hready_int;
  assign HRESP   = hresp_int;

endmodule
